mem_arbiter: RTL

// - Shares one std_mem_intf memory port between SLAVE_PORTS requesters; round-robin grant.
// - Tags every read with its requester index in an in-order tag FIFO.
// - Routes each memory read response back to the requester that issued it.
// - Sits between cores/DMA request ports and a single memory or mem_crossbar master port.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one memory request port
// between SLAVE_PORTS requesters. Every granted read pushes the requester
// index into an in-order tag FIFO, and memory read responses are steered
// back to the requester at the FIFO head.
// Optional feature macro: MEM_ARBITER_STATS_EN adds saturating per-requester
// grant counters on the grant_count port.
module mem_arbiter #(
  parameter int SLAVE_PORTS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  // requester side: requests in
  input  logic [SLAVE_PORTS-1:0]                  slave_req_valid,
  output logic [SLAVE_PORTS-1:0]                  slave_req_ready,
  input  logic [SLAVE_PORTS-1:0]                  slave_req_read_enable,
  input  logic [SLAVE_PORTS-1:0][MASK_WIDTH-1:0]  slave_req_write_enable,
  input  logic [SLAVE_PORTS-1:0][ADDR_WIDTH-1:0]  slave_req_addr,
  input  logic [SLAVE_PORTS-1:0][DATA_WIDTH-1:0]  slave_req_data,
  // requester side: read responses out
  output logic [SLAVE_PORTS-1:0]                  slave_resp_valid,
  input  logic [SLAVE_PORTS-1:0]                  slave_resp_ready,
  output logic [SLAVE_PORTS-1:0][DATA_WIDTH-1:0]  slave_resp_data,
  // memory side: arbitrated request out
  output logic                                    mem_req_valid,
  input  logic                                    mem_req_ready,
  output logic                                    mem_req_read_enable,
  output logic [MASK_WIDTH-1:0]                   mem_req_write_enable,
  output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
  output logic [DATA_WIDTH-1:0]                   mem_req_data,
  // memory side: in-order read responses in
  input  logic                                    mem_resp_valid,
  output logic                                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]                   mem_resp_data
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [SLAVE_PORTS-1:0][31:0]            grant_count
`endif
);

  localparam int IDX_W = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]       rr_ptr;      // round-robin priority: first index scanned
  logic                   load_en;
  logic [SLAVE_PORTS-1:0] eligible;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;

  logic [IDX_W-1:0]       tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       tag_count;
  logic                   tag_empty;
  logic                   tag_full;
  logic [IDX_W-1:0]       head;
  logic                   push;
  logic                   pop;

  // FIFO depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign load_en   = !mem_req_valid || mem_req_ready;
  assign tag_empty = (tag_count == '0);
  // Full is judged on the start-of-cycle count; a same-cycle pop frees nothing.
  assign tag_full  = (tag_count == CNT_W'(MAX_OUTSTANDING));
  assign head      = tag_mem[rd_ptr];

  // Requester eligibility: output register free, and a tag slot for reads.
  always_comb begin
    for (int i = 0; i < SLAVE_PORTS; i++) begin
      eligible[i] = slave_req_valid[i] && load_en &&
                    (!slave_req_read_enable[i] || !tag_full);
    end
  end

  // Round-robin pick: descending scan so the lowest offset from rr_ptr wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = SLAVE_PORTS - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_ptr) + k) % SLAVE_PORTS]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(rr_ptr) + k) % SLAVE_PORTS);
      end
    end
  end

  // Only the granted requester sees ready, in the grant cycle itself.
  always_comb begin
    slave_req_ready = '0;
    if (grant_valid) slave_req_ready[grant_idx] = 1'b1;
  end

  assign push = grant_valid && slave_req_read_enable[grant_idx];
  assign pop  = mem_resp_valid && mem_resp_ready;

  // Request valid: set on grant, dropped once memory takes it with nothing new.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
    end else if (grant_valid) begin
      mem_req_valid <= 1'b1;
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  // Request payload register: captures the winner's fields one cycle after grant.
  always_ff @(posedge clk) begin
    if (grant_valid) begin
      mem_req_read_enable  <= slave_req_read_enable[grant_idx];
      mem_req_write_enable <= slave_req_write_enable[grant_idx];
      mem_req_addr         <= slave_req_addr[grant_idx];
      mem_req_data         <= slave_req_data[grant_idx];
    end
  end

  // Priority advances past the winner; it holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == IDX_W'(SLAVE_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tag FIFO control: pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Tag storage: write the granted index of each read.
  // NOTE: the storage array is not reset; clearing the pointers and count empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  // Response steering: only the head requester sees valid; data is broadcast.
  always_comb begin
    slave_resp_valid = '0;
    for (int i = 0; i < SLAVE_PORTS; i++) slave_resp_data[i] = mem_resp_data;
    if (!tag_empty) slave_resp_valid[head] = mem_resp_valid;
  end

  // With no tag outstanding a stray response is held off rather than dropped.
  assign mem_resp_ready = !tag_empty && slave_resp_ready[head];

`ifdef MEM_ARBITER_STATS_EN
  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
    end else if (grant_valid && (grant_count[grant_idx] != 32'hFFFF_FFFF)) begin
      grant_count[grant_idx] <= grant_count[grant_idx] + 32'd1;
    end
  end
`endif

endmodule
